// File: rtl/cos_pkg.sv
// Shared constants, reciprocal-factorial table and state encoding for the iterative cosine engine.
// Optional macro COS_RANGE_REDUCE_EN adds the REDUCE state to the enum.
package cos_pkg;

  localparam int unsigned ITER_MAX = 8;

  localparam logic signed [31:0] ONE_Q16    = 32'sd65536;
  localparam logic signed [31:0] PI_Q16     = 32'sd205887;
  localparam logic signed [31:0] TWO_PI_Q16 = 32'sd411775;

  // round(2^32 / (2k)!) for k = 1..7
  localparam logic [31:0] RECIP [1:7] = '{
    32'd2147483648, 32'd178956971, 32'd5965232, 32'd106522, 32'd1184, 32'd9, 32'd0
  };

`ifdef COS_RANGE_REDUCE_EN
  typedef enum logic [2:0] {StIdle, StReduce, StSq, StTerm, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StSq, StTerm, StDone} state_e;
`endif

  function automatic logic [31:0] recip_lookup(input logic [3:0] k);
    logic [31:0] r;
    r = '0;
    for (int i = 1; i <= 7; i++) begin
      if (k == 4'(i)) r = RECIP[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cos_term_step.sv
// One Taylor-series step: adds or subtracts num*RECIP[k] and advances num by one power of x^2.
module cos_term_step
  import cos_pkg::*;
(
  input  logic signed [63:0] num_i,
  input  logic signed [63:0] x2_i,
  input  logic        [3:0]  k_i,
  input  logic signed [63:0] sum_i,
  output logic signed [63:0] num_o,
  output logic signed [63:0] sum_o
);

  logic        [95:0]  term_prod;
  logic        [63:0]  term;
  logic signed [127:0] nx_prod;

  // num is non-negative, so the reciprocal product is taken unsigned
  assign term_prod = {32'd0, num_i} * {64'd0, recip_lookup(k_i)};
  assign term      = 64'(term_prod >> 32);
  assign sum_o     = k_i[0] ? (sum_i - $signed(term)) : (sum_i + $signed(term));

  assign nx_prod = 128'(num_i) * 128'(x2_i);
  assign num_o   = 64'(nx_prod >>> 16);

endmodule

// File: rtl/cos_iter_ctrl.sv
// Sequential Q16.16 cosine: one Taylor term per clock through a shared multiply path.
// Define COS_RANGE_REDUCE_EN to fold inputs into [-pi, pi] before the series runs.
module cos_iter_ctrl
  import cos_pkg::*;
#(
  parameter int unsigned ITER = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [31:0] in_x_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [31:0] out_y_o,
  output logic               busy_o
);

  localparam logic [3:0] LastK = 4'(ITER - 1);

  state_e             state_q;
  logic signed [31:0] xr_q;
  logic signed [63:0] x2_q, num_q, sum_q;
  logic        [3:0]  k_q;
  logic signed [31:0] out_y_q;
  logic               out_valid_q, in_ready_q, busy_q;

  logic signed [63:0] sq_prod, sq_x2;
  logic signed [63:0] step_num, step_sum;

  assign sq_prod = xr_q * xr_q;
  assign sq_x2   = sq_prod >>> 16;

  cos_term_step u_step (
    .num_i (num_q),
    .x2_i  (x2_q),
    .k_i   (k_q),
    .sum_i (sum_q),
    .num_o (step_num),
    .sum_o (step_sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      xr_q        <= '0;
      x2_q        <= '0;
      num_q       <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
`ifdef COS_RANGE_REDUCE_EN
            xr_q    <= in_x_i[31] ? -in_x_i : in_x_i;
            state_q <= StReduce;
`else
            xr_q    <= in_x_i;
            state_q <= StSq;
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
`ifdef COS_RANGE_REDUCE_EN
        StReduce: begin
          if (xr_q > PI_Q16) xr_q <= xr_q - TWO_PI_Q16;
          else               state_q <= StSq;
        end
`endif
        StSq: begin
          x2_q  <= sq_x2;
          num_q <= sq_x2;
          sum_q <= 64'(ONE_Q16);
          k_q   <= 4'd1;
          if (ITER > 1) begin
            state_q <= StTerm;
          end else begin
            out_y_q     <= ONE_Q16;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StTerm: begin
          num_q <= step_num;
          sum_q <= step_sum;
          k_q   <= k_q + 4'd1;
          // the result includes the term computed in this final cycle
          if (k_q == LastK) begin
            out_y_q     <= step_sum[31:0];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_y_o     = out_y_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_cos_iter_ctrl.sv
// Directed bench for cos_iter_ctrl (ITER=5 and ITER=1 instances); honours COS_RANGE_REDUCE_EN.
module tb_cos_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_x, out_y;
  logic        in_valid1, in_ready1, out_valid1, busy1;
  logic        out_ready1 = 1'b1;
  logic [31:0] in_x1, out_y1;

  int checks = 0;
  int errors = 0;

`ifdef COS_RANGE_REDUCE_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif

  always #5 clk = ~clk;

  cos_iter_ctrl #(.ITER(5)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_x_i      (in_x),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_y_o     (out_y),
    .busy_o      (busy)
  );

  cos_iter_ctrl #(.ITER(1)) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .in_x_i      (in_x1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .out_y_o     (out_y1),
    .busy_o      (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issue one angle, count cycles until out_valid, check latency and result.
  task automatic run_req(input string tag, input logic [31:0] x, input int exp_lat,
                         input logic [31:0] exp_y);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 32'hDEAD_BEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_y"}, out_y, exp_y);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ack_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ack_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    in_valid1 = 1'b0;
    in_x1     = '0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_req("zero", 32'd0, 6 + Extra, 32'd65536);
    ack("zero");
    run_req("one", 32'd65536, 6 + Extra, 32'd35408);
    ack("one");
    run_req("neg_one", 32'hFFFF_0000, 6 + Extra, 32'd35408);
    ack("neg_one");
    run_req("half", 32'd32768, 6 + Extra, 32'd57513);
    ack("half");
    run_req("two", 32'd131072, 6 + Extra, 32'hFFFF_9589);
    ack("two");

    // Back-pressure in DONE
    run_req("stall", 32'd65536, 6 + Extra, 32'd35408);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_y", out_y, 32'd35408);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
    end
    ack("stall");

    // Reset during the third TERM cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 32'd65536;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4 + Extra) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_out_y", out_y, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_req("after_rst", 32'd65536, 6 + Extra, 32'd35408);
    ack("after_rst");

`ifdef COS_RANGE_REDUCE_EN
    run_req("wrap", 32'd477311, 8, 32'd35408);
    ack("wrap");
`endif

    // ITER=1 instance: SQ then DONE
    @(negedge clk);
    in_valid1 = 1'b1;
    in_x1     = 32'd65536;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid1 && n < 400);
    chk("iter1_lat", 32'(n), 32'(2 + Extra));
    chk("iter1_y", out_y1, 32'd65536);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cos_iter_ctrl.md
# cos_iter_ctrl

Multi-cycle, handshake-driven cosine engine for Q16.16 radian inputs. It sequences a truncated Taylor series (1 − x²/2! + x⁴/4! − …) one term per clock through a single shared multiply path. Division is replaced by a reciprocal-factorial constant table. It is the sequential, area-reduced successor to the team's combinational fixed-point cosine. It sits between a requester issuing angles and a consumer of cos results.

## Interface
- ITER, 5, number of series terms including the constant 1.0; legal range 1..8.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request carries a valid angle.
- in_ready  out  1  engine can accept a request.
- in_x  in  32  signed Q16.16 angle, radians.
- out_valid  out  1  out_y holds a finished result.
- out_ready  in  1  consumer accepts result.
- out_y  out  32  signed Q16.16 cos(in_x).
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REDUCE (only when the macro is compiled in), SQ, TERM, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, capture in_x into xr. Next state is REDUCE if the macro is on, else SQ.
- SQ:
  - x2 ← (xr·xr)>>>16, 64-bit signed.
  - num ← that same value.
  - sum ← 65536 (1.0).
  - k ← 1.
  - Next state is TERM if ITER>1, else DONE.
- TERM, per cycle:
  - term = (num · RECIP[k])>>32, 96-bit unsigned product; num is non-negative.
  - sum ← sum − term when k is odd, sum + term when k is even.
  - num ← (num·x2)>>>16.
  - k ← k+1.
  - After k = ITER−1, load out_y ← sum[31:0] and go to DONE.
- RECIP[k] = round(2³²/(2k)!): 2147483648, 178956971, 5965232, 106522, 1184, 9, 0 for k=1..7.
- DONE: out_valid=1, out_y stable. On out_ready, next state is IDLE; out_valid drops the following cycle.
- Results are only accurate for |x| ≤ 4.0 after reduction. Overflow outside that range wraps silently and deterministically.
- in_x changes while not in IDLE are ignored. out_ready is ignored outside DONE.
- Reset (any time, including mid-TERM or in DONE):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_y=0.
  - All internal registers (xr, x2, num, sum, k) are cleared.
  - The in-flight request is discarded with no result.

## Timing
- Accept on edge T. Without the macro, out_valid is first high in cycle T+ITER+1: SQ at T+1, TERM at T+2..T+ITER, DONE at T+ITER+1.
- ITER=1: SQ then DONE, out_valid at T+2, out_y=65536.
- With the macro: add 1+n cycles, where n is the number of 2π subtractions performed.
- Minimum issue interval is ITER+2 cycles, because IDLE is re-entered one cycle after the output handshake.
- in_ready is a pure function of state (registered). There is no combinational path from in_valid or out_ready to any output.

## Configuration
- Macro: COS_RANGE_REDUCE_EN.
- Defined:
  - Capture stores |in_x|.
  - REDUCE, each cycle: if xr > PI_Q16 (205887), xr ← xr − TWO_PI_Q16 (411775) and stay in REDUCE; else go to SQ.
  - At least one REDUCE cycle is always spent.
  - Result is valid for the full Q16.16 input range. Latency is data-dependent, at most about 5216 extra cycles.
- Undefined:
  - The REDUCE state and its logic are absent.
  - in_x is used as is; cos is even, so the sign needs no handling.

## Structure
- Package cos_pkg holds:
  - ONE_Q16, PI_Q16, TWO_PI_Q16.
  - The RECIP table as a localparam array indexed 1..7.
  - The state enum.
  - ITER_MAX = 8.
- Sub-module cos_term_step, combinational: inputs num, x2, k, sum; outputs next num and next sum. The controller only sequences it and owns all registers.

## Test plan
- ITER=5, in_x=0 accepted at T → out_valid first high at T+6, out_y=65536.
- ITER=5, in_x=65536 (1.0) → out_y=35408 (0x8A50). Same result for in_x=−65536.
- Hold out_ready low 3 cycles in DONE → out_y and out_valid stay stable, in_ready=0, busy=1. Raise out_ready → in_ready high the next cycle.
- Assert rst during the third TERM cycle → all outputs return to reset values immediately. A fresh request for 1.0 then yields 35408 with normal latency.
- ITER=1, in_x=65536 → out_y=65536 at T+2.
- COS_RANGE_REDUCE_EN defined, in_x=477311 (2π+1.0) → exactly one subtraction, out_y=35408, out_valid at T+8. in_x=0 → out_valid at T+7.
